key_event_encoder: RTL and testbench

Front-end input stage for the calculator datapath. It synchronizes and debounces the eleven keypad push switches (digits 0–9 and the clear key `lrd`) and priority-encodes the result. Each confirmed press becomes exactly one key event, carrying a digit code and the matching LCD character code. Events are buffered in a small FIFO and handed downstream over a valid/ready handshake, replacing the ad-hoc one-shot/switch-count logic in the consumer.

---
 rtl/key_event_encoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_key_event_encoder.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_encoder.sv
// rtl/key_event_encoder.sv - keypad synchronizer, debouncer, priority encoder and key event FIFO
//
// Purpose:
//   Turns the eleven raw keypad switches (digits 0-9 plus the clear key on
//   bit 10) into a stream of key events. Each confirmed press yields exactly
//   one event. Events queue in a small circular buffer and leave over a
//   valid/ready handshake.
//
// Parameters:
//   TICK_DIV   - clk cycles per debounce sample tick (>= 2)
//   DEB_CYCLES - consecutive equal samples needed to confirm press/release (>= 2)
//   FIFO_DEPTH - event buffer entries (power of 2)
//
// Ports:
//   i_clk          - system clock, all logic on posedge
//   i_rst          - synchronous active-low reset
//   i_sw[10:0]     - raw asynchronous switch levels (bit 10 = clear key)
//   i_key_ready    - consumer accepts head event when o_key_valid is high
//   o_key_valid    - buffer holds at least one event
//   o_key_code     - head event code, 0-9 digits, 10 clear key (0 when empty)
//   o_key_ascii    - head LCD character (8'h30+digit, 8'h20 for clear/empty)
//   o_fifo_count   - number of buffered events
//   o_overflow     - sticky, an event was dropped because the buffer was full

module key_event_encoder #(
  parameter int TICK_DIV   = 10,
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [10:0]                   i_sw,
  input  logic                          i_key_ready,
  output logic                          o_key_valid,
  output logic [3:0]                    o_key_code,
  output logic [7:0]                    o_key_ascii,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count,
  output logic                          o_overflow
);

  localparam int TCW = $clog2(TICK_DIV);
  localparam int DCW = $clog2(DEB_CYCLES) + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PRESS_DEB,
    S_HELD,
    S_RELEASE_DEB
  } state_t;

  // ---------------------------------------------------------------------------
  // Two-flop synchronizer; only r_sws is used past this point.
  // ---------------------------------------------------------------------------
  logic [10:0] r_sync1;
  logic [10:0] r_sws;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sync1 <= '0;
      r_sws   <= '0;
    end else begin
      r_sync1 <= i_sw;
      r_sws   <= r_sync1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sample tick: one clk pulse every TICK_DIV cycles.
  // ---------------------------------------------------------------------------
  logic [TCW-1:0] r_tick_cnt;
  logic           w_tick;

  assign w_tick = (r_tick_cnt == TCW'(TICK_DIV - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_tick_cnt <= '0;
    end else if (w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Priority encoder: 1..9 first, then 0, then the clear key.
  // ---------------------------------------------------------------------------
  logic [3:0] w_cand;
  logic       w_any;

  assign w_any = |r_sws;

  always_comb begin
    w_cand = 4'd0;
    // Lowest priority is assigned first so that later hits override it.
    if (r_sws[10]) w_cand = 4'd10;
    if (r_sws[0])  w_cand = 4'd0;
    for (int i = 9; i >= 1; i--) begin
      if (r_sws[i]) w_cand = 4'(i);
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM. All transitions are qualified by the sample tick.
  // ---------------------------------------------------------------------------
  state_t         r_state;
  state_t         w_state_nx;
  logic [3:0]     r_lat;
  logic [3:0]     w_lat_nx;
  logic [DCW-1:0] r_dcnt;
  logic [DCW-1:0] w_dcnt_nx;
  logic           w_push;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_lat   <= 4'd0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_lat   <= w_lat_nx;
      r_dcnt  <= w_dcnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_lat_nx   = r_lat;
    w_dcnt_nx  = r_dcnt;
    w_push     = 1'b0;
    if (w_tick) begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            w_lat_nx   = w_cand;
            w_dcnt_nx  = DCW'(1);
            w_state_nx = S_PRESS_DEB;
          end
        end
        S_PRESS_DEB: begin
          // A different winning key restarts the debounce from IDLE.
          if (w_any && (w_cand == r_lat)) begin
            if (r_dcnt == DCW'(DEB_CYCLES - 1)) begin
              w_push     = 1'b1;
              w_state_nx = S_HELD;
            end else begin
              w_dcnt_nx = r_dcnt + 1'b1;
            end
          end else begin
            w_dcnt_nx  = '0;
            w_state_nx = S_IDLE;
          end
        end
        S_HELD: begin
          // No auto-repeat; a code change while held is ignored.
          if (!w_any) begin
            w_dcnt_nx  = DCW'(1);
            w_state_nx = S_RELEASE_DEB;
          end
        end
        S_RELEASE_DEB: begin
          if (w_any) begin
            w_state_nx = S_HELD;
          end else if (r_dcnt == DCW'(DEB_CYCLES - 1)) begin
            w_dcnt_nx  = '0;
            w_state_nx = S_IDLE;
          end else begin
            w_dcnt_nx = r_dcnt + 1'b1;
          end
        end
        default: begin
          w_state_nx = S_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Event FIFO. A push while full succeeds only if a pop frees a slot on
  // the same edge; otherwise the event is dropped and overflow sticks.
  // ---------------------------------------------------------------------------
  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          w_valid;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic [3:0]    w_head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_pop   = w_valid && i_key_ready;
  assign w_wr    = w_push && (!w_full || w_pop);
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= r_lat;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (w_wr && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_push && !w_wr) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Head outputs, forced to idle values while the buffer is empty.
  // ---------------------------------------------------------------------------
  assign o_key_valid  = w_valid;
  assign o_key_code   = w_valid ? w_head : 4'd0;
  assign o_key_ascii  = (!w_valid || (w_head == 4'd10)) ? 8'h20 : (8'h30 + {4'h0, w_head});
  assign o_fifo_count = r_count;
  assign o_overflow   = r_overflow;

endmodule

// File: tb/tb_key_event_encoder.sv
// tb/tb_key_event_encoder.sv - self-checking bench for key_event_encoder
`timescale 1ns/1ps

module tb_key_event_encoder;

  localparam int TD    = 10;
  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [10:0]              sw = '0;
  logic                     key_ready = 1'b0;
  logic                     key_valid;
  logic [3:0]               key_code;
  logic [7:0]               key_ascii;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int base   = 0;

  key_event_encoder #(
    .TICK_DIV   (TD),
    .DEB_CYCLES (DEB),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sw         (sw),
    .i_key_ready  (key_ready),
    .o_key_valid  (key_valid),
    .o_key_code   (key_code),
    .o_key_ascii  (key_ascii),
    .o_fifo_count (fifo_count),
    .o_overflow   (overflow)
  );

  always #5 clk = ~clk;

  // cyc = index of the most recent posedge
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: winning key of a switch mask by keypad priority.
  function automatic int prio(input logic [10:0] m);
    int order [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 10};
    for (int i = 0; i < 11; i++) begin
      if (m[order[i]]) return order[i];
    end
    return -1;
  endfunction

  function automatic logic [7:0] ascii_of(input int c);
    return (c == 10) ? 8'h20 : 8'(8'h30 + c);
  endfunction

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [10:0] m, input int hold, input int gap);
    sw = m;
    clks(hold);
    sw = '0;
    clks(gap);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    clks(n);
    base = cyc;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(3);
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", key_valid); end
    checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
    checks++; if (key_ascii !== 8'h20) begin errors++; $display("FAIL reset_ascii: got %h want 20", key_ascii); end
    checks++; if (fifo_count !== '0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
  endtask

  task automatic test_single_press();
    int n;
    bit seen;
    key_ready = 1'b0;
    sw = 11'd1 << 5;
    n = 0;
    seen = 0;
    while (!seen && n < 100) begin
      @(negedge clk);
      n++;
      if (key_valid === 1'b1) seen = 1;
    end
    // sw changes half a clk before edge 1, so 32..41 clk means edges 33..42
    checks++;
    if (!seen || n < 33 || n > 42) begin
      errors++; $display("FAIL single_latency: valid after %0d edges (seen=%0b) want 33..42", n, seen);
    end
    clks(100 - n);
    sw = '0;
    clks(80);
    checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %0b want 1", key_valid); end
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
    checks++; if (key_code !== 4'd5) begin errors++; $display("FAIL single_code: got %0d want 5", key_code); end
    checks++; if (key_ascii !== 8'h35) begin errors++; $display("FAIL single_ascii: got %h want 35", key_ascii); end
    key_ready = 1'b1;
    clks(1);
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_pop: valid %0b want 0", key_valid); end
  endtask

  task automatic test_bounce();
    key_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sw = (k % 2 == 0) ? 11'h008 : 11'h000;
      clks(15);
    end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL bounce_press_quiet: count %0d want 0", fifo_count); end
    sw = 11'h008;
    clks(80);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL bounce_one_event: count %0d want 1", fifo_count); end
    checks++; if (key_code !== 4'd3) begin errors++; $display("FAIL bounce_code: got %0d want 3", key_code); end
    for (int k = 0; k < 8; k++) begin
      sw = (k % 2 == 0) ? 11'h000 : 11'h008;
      clks(15);
    end
    sw = '0;
    clks(80);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL bounce_release_quiet: count %0d want 1", fifo_count); end
    key_ready = 1'b1;
    clks(1);
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_pop: valid %0b want 0", key_valid); end
  endtask

  task automatic test_priority();
    logic [10:0] masks [3];
    int e;
    masks[0] = 11'h084;
    masks[1] = 11'h401;
    masks[2] = 11'h400;
    key_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      e = prio(masks[k]);
      press(masks[k], 70, 70);
      checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL prio_count[%0d]: got %0d want 1", k, fifo_count); end
      checks++; if (key_code !== 4'(e)) begin errors++; $display("FAIL prio_code[%0d]: got %0d want %0d", k, key_code, e); end
      checks++; if (key_ascii !== ascii_of(e)) begin errors++; $display("FAIL prio_ascii[%0d]: got %h want %h", k, key_ascii, ascii_of(e)); end
      key_ready = 1'b1;
      clks(1);
      key_ready = 1'b0;
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL prio_pop[%0d]: valid %0b want 0", k, key_valid); end
    end
  endtask

  task automatic test_random();
    int exp_q [$];
    int hold, gap;
    logic [10:0] m;
    key_ready = 1'b0;
    for (int k = 0; k < 12; k++) begin
      m = 11'($urandom_range(1, 2047));
      hold = $urandom_range(50, 90);
      gap = $urandom_range(50, 90);
      exp_q.push_back(prio(m));
      for (int t = 0; t < hold + gap + ((k == 11) ? 20 : 0); t++) begin
        sw = (t < hold) ? m : 11'h000;
        key_ready = (k == 11 && t >= hold + gap) ? 1'b1 : 1'($urandom_range(0, 1));
        if (key_valid === 1'b1 && key_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL random_spurious: got code %0d with nothing expected", key_code);
          end else begin
            if (key_code !== 4'(exp_q[0]) || key_ascii !== ascii_of(exp_q[0])) begin
              errors++; $display("FAIL random_event: got %0d/%h want %0d/%h", key_code, key_ascii, exp_q[0], ascii_of(exp_q[0]));
            end
            void'(exp_q.pop_front());
          end
        end
        @(negedge clk);
      end
    end
    key_ready = 1'b0;
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL random_missing: %0d events not seen, want 0", exp_q.size()); end
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL random_drained: valid %0b want 0", key_valid); end
  endtask

  task automatic test_simul_push_pop();
    int exp_q [$];
    logic [10:0] m;
    int s, first, push_edge, guard;
    do_reset(2);
    key_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m = 11'($urandom_range(1, 2047));
      exp_q.push_back(prio(m));
      press(m, 60, 60);
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL simul_full: count %0d want 4", fifo_count); end
    m = 11'($urandom_range(1, 2047));
    s = cyc;
    sw = m;
    // Two sync stages, then the DEB-th tick sample (ticks fall every TD edges after reset).
    first = s + 3;
    while ((first - base) % TD != 0) first++;
    push_edge = first + (DEB - 1) * TD;
    guard = 0;
    while (cyc < push_edge - 1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL simul_before: count %0d want 4", fifo_count); end
    checks++; if (key_code !== 4'(exp_q[0])) begin errors++; $display("FAIL simul_head: got %0d want %0d", key_code, exp_q[0]); end
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(prio(m));
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL simul_count: count %0d want 4", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL simul_overflow: got %0b want 0", overflow); end
    clks(30);
    sw = '0;
    clks(60);
    key_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (key_valid !== 1'b1 || key_code !== 4'(exp_q[i])) begin
        errors++; $display("FAIL simul_order[%0d]: valid %0b code %0d want code %0d", i, key_valid, key_code, exp_q[i]);
      end
      @(negedge clk);
    end
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL simul_empty: valid %0b want 0", key_valid); end
  endtask

  task automatic test_overflow();
    key_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      press(11'(1 << k), 60, 60);
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b want 1", overflow); end
    key_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (key_valid !== 1'b1 || key_code !== 4'(k)) begin
        errors++; $display("FAIL ovf_drain[%0d]: valid %0b code %0d want code %0d", k, key_valid, key_code, k);
      end
      @(negedge clk);
    end
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty: valid %0b want 0", key_valid); end
    clks(5);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %0b want 1", overflow); end
  endtask

  task automatic test_reset_mid();
    int n;
    bit seen;
    key_ready = 1'b0;
    press(11'h010, 60, 60);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rmid_pending: count %0d want 1", fifo_count); end
    sw = 11'h200;
    clks(20);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({key_valid, key_code, key_ascii, fifo_count, overflow} !== {1'b0, 4'd0, 8'h20, 3'd0, 1'b0}) begin
        errors++; $display("FAIL rmid_in_reset[%0d]: valid %0b code %0d ascii %h count %0d ovf %0b want 0 0 20 0 0",
                           i, key_valid, key_code, key_ascii, fifo_count, overflow);
      end
    end
    base = cyc;
    rst = 1'b1;
    n = 0;
    seen = 0;
    while (!seen && n < 80) begin
      @(negedge clk);
      n++;
      if (key_valid === 1'b1) seen = 1;
    end
    checks++; if (!seen || n < 33 || n > 42) begin errors++; $display("FAIL rmid_latency: valid after %0d edges (seen=%0b) want 33..42", n, seen); end
    checks++; if (key_code !== 4'd9) begin errors++; $display("FAIL rmid_code: got %0d want 9", key_code); end
    clks(30);
    sw = '0;
    clks(60);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rmid_single: count %0d want 1", fifo_count); end
    key_ready = 1'b1;
    clks(1);
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL rmid_pop: valid %0b want 0", key_valid); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_press();
    test_bounce();
    test_priority();
    test_random();
    test_simul_push_pop();
    test_overflow();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
